matmul_sequencer: RTL and testbench

Instruction-driven sequencer for the 2x2 systolic-array datapath. It accepts 16-bit instructions over a valid/ready handshake and drives the datapath control strobes in order:
- load_weight and load_input, for the weight memory and unified buffer;
- valid, for input_setup, mmu and the accumulators;
- store, for the unified buffer.

It waits on the accumulator full flags before allowing a store. It replaces hard-wired start-to-finish sequencing with a programmable, checked instruction stream.

---
 rtl/tpu_ctrl_pkg.sv | 34 +++
 rtl/seq_timer.sv | 28 ++
 rtl/matmul_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared types and field layout for the systolic-array control sequencer.
// Instruction word: opcode in the top bits, base address in the rest.
package tpu_ctrl_pkg;

  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 13;
  localparam int unsigned ADDR_MSB = 12;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned RET_W    = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'd0,
    OP_LDW = 3'd1,
    OP_LDI = 3'd2,
    OP_CMP = 3'd3,
    OP_STR = 3'd4,
    OP_HLT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC_LDW,
    ST_EXEC_LDI,
    ST_EXEC_CMP,
    ST_WAIT_ACC,
    ST_EXEC_STR,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; shared by the compute window
// and the accumulator-full timeout.
module seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_c_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// Instruction-driven sequencer for the 2x2 systolic array: fetches 16-bit
// instructions and issues load/compute/store strobes, all outputs registered.
module matmul_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 4,
  parameter int unsigned ACC_TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               acc1_full,
  input  logic               acc2_full,
  output logic [ADDR_W-1:0]  base_address,
  output logic               load_weight,
  output logic               load_input,
  output logic               valid,
  output logic               store,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned TMR_MAX = (ACC_TIMEOUT > COMPUTE_CYCLES) ? ACC_TIMEOUT : COMPUTE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic               lw_q, lw_d, li_q, li_d, valid_q, valid_d, store_q, store_d;
  logic               done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic               retire;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;
  logic [OPC_W-1:0]   opc;
  logic [ADDR_W-1:0]  addr;

  assign opc  = instr_data[OPC_MSB:OPC_LSB];
  assign addr = instr_data[ADDR_MSB:ADDR_LSB];

  seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_c_o   (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      lw_q      <= 1'b0;
      li_q      <= 1'b0;
      valid_q   <= 1'b0;
      store_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      lw_q      <= lw_d;
      li_q      <= li_d;
      valid_q   <= valid_d;
      store_q   <= store_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Strobes are computed from the transition so they appear in the first cycle of the new state.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    err_d    = err_q;
    pend_d   = pend_q;
    lw_d     = 1'b0;
    li_d     = 1'b0;
    valid_d  = 1'b0;
    store_d  = 1'b0;
    done_d   = 1'b0;
    retire   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          if ((opc != OP_NOP) && (opc != OP_HLT)) base_d = addr;
          case (opc)
            OP_NOP: retire = 1'b1;
            OP_LDW: begin
              state_d = ST_EXEC_LDW;
              lw_d    = 1'b1;
            end
            OP_LDI: begin
              state_d = ST_EXEC_LDI;
              li_d    = 1'b1;
            end
            OP_CMP: begin
              state_d  = ST_EXEC_CMP;
              valid_d  = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(COMPUTE_CYCLES - 1);
            end
            OP_STR: begin
              state_d = ST_EXEC_STR;
              store_d = pend_q;
            end
            OP_HLT: begin
              state_d = ST_HALTED;
              done_d  = 1'b1;
              retire  = 1'b1;
            end
            default: begin
              err_d  = 1'b1;
              retire = 1'b1;
            end
          endcase
        end
      end
      ST_EXEC_LDW, ST_EXEC_LDI: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_EXEC_CMP: begin
        if (tmr_zero) begin
          state_d  = ST_WAIT_ACC;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ACC_TIMEOUT - 1);
        end else begin
          valid_d = 1'b1;
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_ACC: begin
        if (acc1_full && acc2_full) begin
          state_d = ST_FETCH;
          pend_d  = 1'b1;
          retire  = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_FETCH;
          err_d   = 1'b1;
          retire  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_EXEC_STR: begin
        state_d = ST_FETCH;
        pend_d  = 1'b0;
        retire  = 1'b1;
        if (!pend_q) err_d = 1'b1;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase

    retired_d = retire ? retired_q + RET_W'(1) : retired_q;
    ready_d   = (state_d == ST_FETCH);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_HALTED);
  end

  assign instr_ready  = ready_q;
  assign base_address = base_q;
  assign load_weight  = lw_q;
  assign load_input   = li_q;
  assign valid        = valid_q;
  assign store        = store_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scenario bench for matmul_sequencer plus a randomized program checked
// against an instruction-level model of retired count, error, address and pending result.
module tb_matmul_sequencer;

  localparam logic [2:0] NOP = 3'd0, LDW = 3'd1, LDI = 3'd2, CMP = 3'd3, STR = 3'd4, HLT = 3'd7;

  logic        clk = 1'b0;
  logic        reset, start, instr_valid, acc1_full, acc2_full;
  logic [15:0] instr_data;
  logic        instr_ready, load_weight, load_input, valid, store, busy, done, err;
  logic [12:0] base_address;
  logic [7:0]  retired;

  int total = 0;
  int bad   = 0;

  matmul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .acc1_full    (acc1_full),
    .acc2_full    (acc2_full),
    .base_address (base_address),
    .load_weight  (load_weight),
    .load_input   (load_input),
    .valid        (valid),
    .store        (store),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {load_weight, load_input, valid, store};
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
    acc1_full = 1'b0; acc2_full = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one instruction and returns in the cycle after the accepting edge.
  task automatic issue(input logic [2:0] opc, input logic [12:0] addr, output bit ok);
    ok = 1'b0;
    instr_data  = {opc, addr};
    instr_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (instr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    instr_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL issue_timeout opc=%0d got instr_ready=%b exp=1", opc, instr_ready); end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL rst_strobes got=%b exp=0000", strobes()); end
    total++; if ({instr_ready, busy, done, err} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {instr_ready, busy, done, err}); end
    total++; if (base_address !== 13'h0) begin bad++; $display("FAIL rst_base got=%h exp=0", base_address); end
    total++; if (retired !== 8'd0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    instr_data = {LDW, 13'h0123};
    instr_valid = 1'b1;
    repeat (3) tick();
    instr_valid = 1'b0;
    total++; if ({instr_ready, strobes(), busy} !== 6'b0) begin bad++; $display("FAIL idle_ignores_valid got=%b exp=000000", {instr_ready, strobes(), busy}); end
    total++; if (base_address !== 13'h0) begin bad++; $display("FAIL idle_base got=%h exp=0", base_address); end
  endtask

  task automatic test_full_program();
    bit ok;
    int c;
    do_reset();
    pulse_start();
    total++; if ({instr_ready, busy} !== 2'b11) begin bad++; $display("FAIL fp_fetch got=%b exp=11", {instr_ready, busy}); end
    issue(LDW, 13'h0000, ok);
    total++; if (strobes() !== 4'b1000 || base_address !== 13'h0000) begin bad++; $display("FAIL fp_ldw got=%b/%h exp=1000/0000", strobes(), base_address); end
    tick();
    total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL fp_ldw_len got=%b exp=0000", strobes()); end
    issue(LDI, 13'h0010, ok);
    total++; if (strobes() !== 4'b0100 || base_address !== 13'h0010) begin bad++; $display("FAIL fp_ldi got=%b/%h exp=0100/0010", strobes(), base_address); end
    tick();
    total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL fp_ldi_len got=%b exp=0000", strobes()); end
    issue(CMP, 13'h0000, ok);
    c = 0;
    while (strobes() === 4'b0010 && c < 10) begin c++; tick(); end
    total++; if (c !== 4) begin bad++; $display("FAIL fp_valid_len got=%0d exp=4", c); end
    tick();
    acc1_full = 1'b1; acc2_full = 1'b1;
    tick();
    acc1_full = 1'b0; acc2_full = 1'b0;
    total++; if (instr_ready !== 1'b1 || retired !== 8'd3) begin bad++; $display("FAIL fp_wait_exit got=%b/%0d exp=1/3", instr_ready, retired); end
    issue(STR, 13'h0020, ok);
    total++; if (strobes() !== 4'b0001 || base_address !== 13'h0020) begin bad++; $display("FAIL fp_str got=%b/%h exp=0001/0020", strobes(), base_address); end
    tick();
    total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL fp_str_len got=%b exp=0000", strobes()); end
    issue(HLT, 13'h0000, ok);
    total++; if ({done, err, instr_ready, busy} !== 4'b1000 || retired !== 8'd5) begin bad++; $display("FAIL fp_halt got=%b/%0d exp=1000/5", {done, err, instr_ready, busy}, retired); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL fp_done_len got=%b exp=0", done); end
  endtask

  task automatic test_str_no_pending();
    bit ok;
    do_reset();
    pulse_start();
    issue(STR, 13'h0005, ok);
    total++; if (store !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL nps_exec got=%b%b exp=00", store, err); end
    tick();
    total++; if (store !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL nps_err got=%b%b exp=01", store, err); end
    issue(HLT, 13'h0000, ok);
    total++; if (done !== 1'b1 || retired !== 8'd2) begin bad++; $display("FAIL nps_halt got=%b/%0d exp=1/2", done, retired); end
  endtask

  task automatic test_acc_timeout();
    bit ok;
    int c, n;
    do_reset();
    pulse_start();
    acc1_full = 1'b1; acc2_full = 1'b0;
    issue(CMP, 13'h0777, ok);
    c = 0;
    while (valid === 1'b1 && c < 10) begin c++; tick(); end
    total++; if (c !== 4) begin bad++; $display("FAIL to_valid_len got=%0d exp=4", c); end
    // n counts edges from valid falling to err rising.
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL to_latency got=%0d exp=16", n); end
    total++; if (instr_ready !== 1'b1 || retired !== 8'd1) begin bad++; $display("FAIL to_fetch got=%b/%0d exp=1/1", instr_ready, retired); end
    acc1_full = 1'b0;
    issue(STR, 13'h0001, ok);
    total++; if (store !== 1'b0) begin bad++; $display("FAIL to_no_store got=%b exp=0", store); end
  endtask

  task automatic test_illegal_stall();
    bit ok;
    int rdy;
    int strb;
    do_reset();
    pulse_start();
    issue(3'd5, 13'h1ABC, ok);
    total++; if (err !== 1'b1 || base_address !== 13'h1ABC) begin bad++; $display("FAIL ill_err_base got=%b/%h exp=1/1abc", err, base_address); end
    total++; if (strobes() !== 4'b0000 || retired !== 8'd1) begin bad++; $display("FAIL ill_strobe_ret got=%b/%0d exp=0000/1", strobes(), retired); end
    rdy = 0; strb = 0;
    for (int i = 0; i < 10; i++) begin
      if (instr_ready === 1'b1) rdy++;
      if (strobes() !== 4'b0000) strb++;
      tick();
    end
    total++; if (rdy !== 10 || strb !== 0) begin bad++; $display("FAIL ill_stall got=%0d/%0d exp=10/0", rdy, strb); end
    issue(3'd6, 13'h0042, ok);
    total++; if (base_address !== 13'h0042 || retired !== 8'd2 || instr_ready !== 1'b1) begin bad++; $display("FAIL ill6 got=%h/%0d/%b exp=0042/2/1", base_address, retired, instr_ready); end
  endtask

  task automatic test_reset_mid_compute();
    bit ok;
    do_reset();
    pulse_start();
    issue(3'd6, 13'h0000, ok);
    issue(LDI, 13'h0123, ok);
    issue(CMP, 13'h0456, ok);
    tick();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rmc_valid2 got=%b exp=1", valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (strobes() !== 4'b0000 || {instr_ready, busy, err} !== 3'b000) begin bad++; $display("FAIL rmc_abort got=%b/%b exp=0000/000", strobes(), {instr_ready, busy, err}); end
    total++; if (retired !== 8'd0 || base_address !== 13'h0) begin bad++; $display("FAIL rmc_clear got=%0d/%h exp=0/0", retired, base_address); end
    tick();
    total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL rmc_quiet got=%b exp=0000", strobes()); end
    pulse_start();
    issue(LDW, 13'h00AA, ok);
    total++; if (strobes() !== 4'b1000 || base_address !== 13'h00AA) begin bad++; $display("FAIL rmc_restart got=%b/%h exp=1000/00aa", strobes(), base_address); end
  endtask

  task automatic test_start_halted();
    bit ok;
    int c, dn;
    do_reset();
    pulse_start();
    pulse_start();
    total++; if ({instr_ready, busy, strobes()} !== 6'b110000) begin bad++; $display("FAIL sh_fetch_start got=%b exp=110000", {instr_ready, busy, strobes()}); end
    issue(CMP, 13'h0003, ok);
    pulse_start();
    c = 1;
    while (valid === 1'b1 && c < 10) begin c++; tick(); end
    total++; if (c !== 4) begin bad++; $display("FAIL sh_cmp_start got=%0d exp=4", c); end
    acc1_full = 1'b1; acc2_full = 1'b1;
    tick();
    acc1_full = 1'b0; acc2_full = 1'b0;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL sh_wait1 got=%b exp=1", instr_ready); end
    issue(HLT, 13'h0000, ok);
    dn = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 1);
      tick();
      if (done === 1'b1) dn++;
    end
    start = 1'b0;
    total++; if ({instr_ready, busy} !== 2'b00) begin bad++; $display("FAIL sh_halted got=%b exp=00", {instr_ready, busy}); end
    total++; if (dn !== 1) begin bad++; $display("FAIL sh_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    longint t0, t1;
    int gaps;
    do_reset();
    pulse_start();
    gaps = 0;
    issue(LDW, 13'h0001, ok);
    t0 = $time;
    for (int i = 0; i < 5; i++) begin
      issue((i % 2 == 0) ? LDI : LDW, 13'(i + 2), ok);
      t1 = $time;
      if (t1 - t0 != 20 || strobes() === 4'b0000) gaps++;
      t0 = t1;
    end
    total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_rate got=%0d bad gaps exp=0", gaps); end
  endtask

  task automatic test_random_program();
    bit ok;
    logic [7:0]  m_ret;
    logic        m_err, m_pend;
    logic [12:0] m_base, addr;
    logic [2:0]  opc;
    logic [3:0]  exp_s;
    int c, d, w, exp_w, vbad;
    do_reset();
    m_ret = 8'd0; m_err = 1'b0; m_pend = 1'b0; m_base = 13'h0;
    pulse_start();
    for (int n = 0; n < 300; n++) begin
      opc  = 3'($urandom_range(0, 6));
      addr = 13'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      issue(opc, addr, ok);
      if (!ok) return;
      if (opc != NOP) m_base = addr;
      case (opc)
        LDW, LDI, STR: begin
          exp_s = (opc == LDW) ? 4'b1000 : (opc == LDI) ? 4'b0100 : {3'b000, m_pend};
          total++; if (strobes() !== exp_s) begin bad++; $display("FAIL rnd_strobe n=%0d opc=%0d got=%b exp=%b", n, opc, strobes(), exp_s); end
          tick();
          if (opc == STR) begin
            if (!m_pend) m_err = 1'b1;
            m_pend = 1'b0;
          end
        end
        CMP: begin
          c = 0;
          while (valid === 1'b1 && c < 10) begin c++; tick(); end
          total++; if (c !== 4) begin bad++; $display("FAIL rnd_valid_len n=%0d got=%0d exp=4", n, c); end
          d = $urandom_range(0, 20);
          w = 0; vbad = 0;
          while (instr_ready !== 1'b1 && w < 40) begin
            if (w == d) {acc1_full, acc2_full} = 2'b11;
            else        {acc1_full, acc2_full} = 2'($urandom_range(0, 2));
            if (valid !== 1'b0) vbad++;
            tick();
            w++;
          end
          {acc1_full, acc2_full} = 2'b00;
          exp_w = (d < 16) ? d + 1 : 16;
          total++; if (w !== exp_w || vbad !== 0) begin bad++; $display("FAIL rnd_wait n=%0d d=%0d got=%0d/%0d exp=%0d/0", n, d, w, vbad, exp_w); end
          if (d < 16) m_pend = 1'b1;
          else        m_err  = 1'b1;
        end
        default: begin
          total++; if (strobes() !== 4'b0000) begin bad++; $display("FAIL rnd_nostrobe n=%0d opc=%0d got=%b exp=0000", n, opc, strobes()); end
          if (opc != NOP) m_err = 1'b1;
        end
      endcase
      m_ret = m_ret + 8'd1;
      total++; if (instr_ready !== 1'b1 || retired !== m_ret) begin bad++; $display("FAIL rnd_retired n=%0d got=%b/%0d exp=1/%0d", n, instr_ready, retired, m_ret); end
      total++; if (err !== m_err || base_address !== m_base) begin bad++; $display("FAIL rnd_state n=%0d got=%b/%h exp=%b/%h", n, err, base_address, m_err, m_base); end
    end
    issue(HLT, 13'h1FFF, ok);
    m_ret = m_ret + 8'd1;
    total++; if (done !== 1'b1 || retired !== m_ret || base_address !== m_base) begin bad++; $display("FAIL rnd_halt got=%b/%0d/%h exp=1/%0d/%h", done, retired, base_address, m_ret, m_base); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
    acc1_full = 1'b0; acc2_full = 1'b0;
    tick();
    test_reset();
    test_full_program();
    test_str_no_pending();
    test_acc_timeout();
    test_illegal_stall();
    test_reset_mid_compute();
    test_start_halted();
    test_back_to_back();
    test_random_program();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
